fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_addr  output  16  instruction memory address; equals the current PC.
REQ-005 imem_rd_en  output  1  read strobe; imem_rdata is valid exactly one cycle later.
REQ-006 imem_rdata  input  32  instruction word returned by the memory.
REQ-007 stall  input  1  hold the decode register (STALL_control OR-ed with hazard stalls).
REQ-008 redirect  input  1  taken branch or jump this cycle.
REQ-009 redirect_pc  input  16  target PC for a redirect.
REQ-010 halt  input  1  decoded HALT from the control unit.
REQ-011 instr  output  32  decode register contents.
REQ-012 instr_valid  output  1  instr holds a real fetched instruction (0 = bubble).
REQ-013 opcode / x_bit / wait_time  output  5 / 1 / 11  fields of instr: [31:27], [26] and [10:0].
REQ-014 pc_plus1  output  16  address of instr + 1, for pcr_to_reg.
REQ-015 halted  output  1  fetch has stopped permanently until reset.

Function
REQ-016 States SHALL be RUN and HALTED; RUN->HALTED on halt=1; HALTED is left only by reset.
REQ-017 imem_rd_en SHALL equal (state==RUN) & ~stall & ~redirect & ~halt; PC SHALL increment by 1 in every cycle imem_rd_en=1.
REQ-018 PC SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-019 A 1-bit rd_pending flag SHALL register imem_rd_en; imem_rdata is consumed only when rd_pending=1.
REQ-020 Advance cycle (~stall, ~redirect): decode register loads the skid entry if skid is valid (skid then cleared), else imem_rdata if rd_pending, else a bubble.
REQ-021 Stall cycle (~redirect): decode register, its PC and the PC SHALL hold; if rd_pending, imem_rdata SHALL be captured in a 1-entry skid.
REQ-022 Redirect SHALL take priority over stall: PC<=redirect_pc, skid cleared, the in-flight read discarded, decode register loaded with a bubble.
REQ-023 A bubble SHALL be instr=NOP_INSTR (32'h7800_0000: opcode 5'b01111, wait 0) with instr_valid=0.
REQ-024 In HALTED: imem_rd_en=0, redirect ignored, instr_valid=0 from the first HALTED cycle, halted=1.
REQ-025 halt and redirect in the same cycle: halt wins and the PC does not change.
REQ-026 Fetch latency: after rst_n deasserts, the first instr_valid=1 SHALL occur on the second rising edge, with no stall.
REQ-027 Skid depth 1 SHALL suffice because no read is issued while stalled; skid overflow SHALL be impossible by construction.

Reset
REQ-028 Asynchronous reset values: PC=RESET_PC, state=RUN, instr=NOP_INSTR, instr_valid=0, skid empty, rd_pending=0, halted=0, counters=0.
REQ-029 imem_rd_en SHALL be 0 while rst_n=0.
REQ-030 Reset mid-stall or mid-redirect SHALL discard all in-flight data.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined: add outputs fetch_cnt[31:0] (increments per instr_valid=1 advance) and stall_cnt[31:0] (increments per stall=1 cycle in RUN); both saturate at 32'hFFFF_FFFF.
REQ-032 Without FETCH_PERF_CNT_EN: neither port nor counter logic exists, and all other behaviour is identical.

Structure
REQ-033 Shared package cpu_pkg SHALL hold: opcode constants (AND..NOP 5'b00000..5'b01111, HALT 5'b11111), NOP_INSTR, field bit-position constants, the fetch state enum.
REQ-034 The skid register SHALL be sub-module fetch_skid_buf (ports: capture, consume, flush, data in/out, valid).

Verification
REQ-035 Reset release, memory returns 0x2000_0001 at addr 0 and 0x0800_0002 at addr 1 -> instr_valid at edge 2 with opcode ADD; next cycle opcode OR; pc_plus1 = 1 then 2.
REQ-036 stall held 5 cycles mid-stream -> imem_rd_en=0 and instr constant throughout; after release, the skid word appears first and no address is skipped or repeated.
REQ-037 redirect with redirect_pc=16'h0040 while stalled -> next instr is a bubble, imem_addr=0x0040, the in-flight word is never presented.
REQ-038 RESET_PC=16'hFFFF -> addresses FFFF then 0000.
REQ-039 halt together with redirect -> halted=1, imem_rd_en=0 forever, instr_valid=0, and a later redirect has no effect.
REQ-040 With FETCH_PERF_CNT_EN: 10 fetches and 3 stall cycles -> fetch_cnt=10, stall_cnt=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, NOP encoding, instruction field
// positions and the fetch state type.
package cpu_pkg;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_NOT  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_LD   = 5'b01001;
    localparam logic [4:0] OP_ST   = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b01100;
    localparam logic [4:0] OP_MOV  = 5'b01101;
    localparam logic [4:0] OP_PCR  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Bubble word: NOP opcode, x_bit clear, wait_time 0.
    localparam logic [31:0] NOP_INSTR = {OP_NOP, 27'd0};

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int X_BIT_POS  = 26;
    localparam int WAIT_MSB   = 10;
    localparam int WAIT_LSB   = 0;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port of the fetch stage.
// Fixed-latency read: when imem_rd_en=1 at a rising edge the memory presents
// the word for imem_addr on imem_rdata for the whole following cycle; there is
// no ready/backpressure, the requester simply never issues while it cannot sink.
interface fetch_unit_if;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, output imem_rd_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_rd_en, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a read word that returns while decode is stalled.
module fetch_skid_buf #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture,
    input  logic         consume,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, imem read strobe, decode register with skid entry.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    input  logic         halt,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [4:0]   opcode,
    output logic         x_bit,
    output logic [10:0]  wait_time,
    output logic [15:0]  pc_plus1,
    output logic         halted,
    output fetch_state_e state_dbg
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    fetch_state_e state;
    logic [15:0]  pc;
    logic [15:0]  pend_pc;
    logic         rd_pending;
    logic         running;
    logic         rd_en;
    logic         advance;
    logic         skid_capture;
    logic         skid_consume;
    logic         skid_flush;
    logic         skid_valid;
    logic [47:0]  skid_dout;
    logic [15:0]  skid_pc;
    logic [31:0]  skid_data;

    assign running      = (state == FETCH_RUN);
    // No read is issued while stalled, so the skid can never hold two words.
    assign rd_en        = rst_n & running & ~stall & ~redirect & ~halt;
    assign advance      = running & ~halt & ~redirect & ~stall;
    assign skid_capture = running & ~halt & ~redirect & stall & rd_pending;
    assign skid_consume = advance & skid_valid;
    assign skid_flush   = ~running | halt | redirect;
    assign {skid_pc, skid_data} = skid_dout;

    assign imem.imem_addr  = pc;
    assign imem.imem_rd_en = rd_en;

    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign x_bit     = instr[X_BIT_POS];
    assign wait_time = instr[WAIT_MSB:WAIT_LSB];
    assign state_dbg = state;

    fetch_skid_buf #(.W(48)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (skid_capture),
        .consume (skid_consume),
        .flush   (skid_flush),
        .din     ({pend_pc, imem.imem_rdata}),
        .dout    (skid_dout),
        .valid   (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            pend_pc     <= RESET_PC;
            rd_pending  <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            pc_plus1    <= '0;
            halted      <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            if (rd_en) begin
                pc      <= pc + 16'd1;
                pend_pc <= pc;
            end
            case (state)
                FETCH_RUN: begin
                    if (halt) begin
                        state       <= FETCH_HALTED;
                        halted      <= 1'b1;
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end else if (redirect) begin
                        // The word returning this cycle belongs to the old path.
                        pc          <= redirect_pc;
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        if (skid_valid) begin
                            instr       <= skid_data;
                            instr_valid <= 1'b1;
                            pc_plus1    <= skid_pc + 16'd1;
                        end else if (rd_pending) begin
                            instr       <= imem.imem_rdata;
                            instr_valid <= 1'b1;
                            pc_plus1    <= pend_pc + 16'd1;
                        end else begin
                            instr       <= NOP_INSTR;
                            instr_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    halted      <= 1'b1;
                    instr       <= NOP_INSTR;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_valid;
    assign load_valid = advance & (skid_valid | rd_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (load_valid && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (running && stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based model of the fetch stream.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] NOP_W = 32'h7800_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    fetch_unit_if mif ();
    fetch_unit_if mif2 ();

    logic         stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [15:0]  redirect_pc = 16'h0000;
    logic [31:0]  instr;
    logic         instr_valid, x_bit, halted;
    logic [4:0]   opcode;
    logic [10:0]  wait_time;
    logic [15:0]  pc_plus1;
    fetch_state_e state_dbg;

    logic         stall2 = 1'b0, redirect2 = 1'b0, halt2 = 1'b0;
    logic [15:0]  redirect_pc2 = 16'h0000;
    logic [31:0]  instr2;
    logic         instr_valid2, x_bit2, halted2;
    logic [4:0]   opcode2;
    logic [10:0]  wait_time2;
    logic [15:0]  pc_plus1_2;
    fetch_state_e state_dbg2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem(mif),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .x_bit(x_bit),
        .wait_time(wait_time), .pc_plus1(pc_plus1), .halted(halted), .state_dbg(state_dbg)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem(mif2),
        .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2), .halt(halt2),
        .instr(instr2), .instr_valid(instr_valid2), .opcode(opcode2), .x_bit(x_bit2),
        .wait_time(wait_time2), .pc_plus1(pc_plus1_2), .halted(halted2), .state_dbg(state_dbg2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
`endif
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_seed = 32'h5A3C_96E1;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 32'h2000_0001;
        if (a == 16'h0001) return 32'h0800_0002;
        return {a, ~a} ^ mem_seed;
    endfunction

    initial begin
        mif.imem_rdata  = 32'h0;
        mif2.imem_rdata = 32'h0;
    end

    // Unread cycles return junk so a consume without a pending read is visible.
    always @(posedge clk) begin
        if (mif.imem_rd_en) mif.imem_rdata <= mem_word(mif.imem_addr);
        else                mif.imem_rdata <= $urandom;
        if (mif2.imem_rd_en) mif2.imem_rdata <= mem_word(mif2.imem_addr);
        else                 mif2.imem_rdata <= $urandom;
    end

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];          // addresses fetched but not yet presented
    logic [15:0] m_pc;
    logic        m_halted;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [15:0] exp_pp1;
    logic        exp_rd_en;
    logic [15:0] exp_addr;
    int          m_fetch_cnt, m_stall_cnt;
    logic        obs_rd_en;
    logic [15:0] obs_addr, obs2_addr;

    task automatic model_reset();
        exp_q.delete();
        m_pc        = 16'h0000;
        m_halted    = 1'b0;
        exp_instr   = NOP_W;
        exp_valid   = 1'b0;
        exp_pp1     = 16'h0000;
        m_fetch_cnt = 0;
        m_stall_cnt = 0;
    endtask

    task automatic reset_dut();
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle starting at a falling edge; samples the combinational
    // outputs before the rising edge and advances the model across it.
    task automatic drive_cycle(input logic st, input logic rd, input logic [15:0] rpc, input logic hl);
        logic [15:0] a;
        stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
        #1;
        exp_rd_en = !m_halted && !st && !rd && !hl;
        exp_addr  = m_pc;
        obs_rd_en = mif.imem_rd_en;
        obs_addr  = mif.imem_addr;
        obs2_addr = mif2.imem_addr;
        @(posedge clk);
        if (!m_halted) begin
            if (st) m_stall_cnt++;
            if (hl) begin
                m_halted = 1'b1;
                exp_q.delete();
                exp_instr = NOP_W;
                exp_valid = 1'b0;
            end else if (rd) begin
                m_pc = rpc;
                exp_q.delete();
                exp_instr = NOP_W;
                exp_valid = 1'b0;
            end else if (!st) begin
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    exp_instr = mem_word(a);
                    exp_valid = 1'b1;
                    exp_pp1   = a + 16'd1;
                    m_fetch_cnt++;
                end else begin
                    exp_instr = NOP_W;
                    exp_valid = 1'b0;
                end
            end
            if (exp_rd_en) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 16'd1;
            end
        end else begin
            exp_instr = NOP_W;
            exp_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #13;
        checks += 6;
        if (mif.imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mif.imem_rd_en); end
        if (mif.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", mif.imem_addr); end
        if (instr !== NOP_W) begin errors++; $display("FAIL reset_instr got %h want %h", instr, NOP_W); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        if (mif2.imem_addr !== 16'hFFFF) begin errors++; $display("FAIL reset_addr2 got %h want ffff", mif2.imem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        // Reset arrives mid-stall with a word sitting in the skid.
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (mif.imem_rd_en !== 1'b0) begin errors++; $display("FAIL midreset_rd_en got %b want 0", mif.imem_rd_en); end
        if (mif.imem_addr !== 16'h0000) begin errors++; $display("FAIL midreset_addr got %h want 0000", mif.imem_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", instr_valid); end
        if (instr !== NOP_W) begin errors++; $display("FAIL midreset_instr got %h want %h", instr, NOP_W); end
        stall = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 2;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid got %b want 1", instr_valid); end
        if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL postreset_pc1 got %h want 0001", pc_plus1); end
    endtask

    task automatic test_first_fetch();
        reset_dut();
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 3;
        if (obs_rd_en !== 1'b1) begin errors++; $display("FAIL ff_rd_en got %b want 1", obs_rd_en); end
        if (obs_addr !== 16'h0000) begin errors++; $display("FAIL ff_addr got %h want 0000", obs_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_edge1_valid got %b want 0", instr_valid); end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 4;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_edge2_valid got %b want 1", instr_valid); end
        if (opcode !== 5'd4) begin errors++; $display("FAIL ff_opcode_add got %b want 00100", opcode); end
        if (wait_time !== 11'd1) begin errors++; $display("FAIL ff_wait1 got %0d want 1", wait_time); end
        if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL ff_pc1 got %h want 0001", pc_plus1); end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 4;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_edge3_valid got %b want 1", instr_valid); end
        if (opcode !== 5'd1) begin errors++; $display("FAIL ff_opcode_or got %b want 00001", opcode); end
        if (wait_time !== 11'd2) begin errors++; $display("FAIL ff_wait2 got %0d want 2", wait_time); end
        if (pc_plus1 !== 16'h0002) begin errors++; $display("FAIL ff_pc2 got %h want 0002", pc_plus1); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [15:0] held_pp1;
        repeat (4) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        held = instr;
        held_pp1 = exp_pp1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
            checks += 3;
            if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en cyc %0d got %b want 0", i, obs_rd_en); end
            if (instr !== held) begin errors++; $display("FAIL stall_hold cyc %0d got %h want %h", i, instr, held); end
            if (instr !== exp_instr) begin errors++; $display("FAIL stall_model cyc %0d got %h want %h", i, instr, exp_instr); end
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
            checks += 4;
            if (obs_addr !== exp_addr) begin errors++; $display("FAIL rel_addr cyc %0d got %h want %h", i, obs_addr, exp_addr); end
            if (instr !== exp_instr) begin errors++; $display("FAIL rel_instr cyc %0d got %h want %h", i, instr, exp_instr); end
            if (instr_valid !== exp_valid) begin errors++; $display("FAIL rel_valid cyc %0d got %b want %b", i, instr_valid, exp_valid); end
            if (pc_plus1 !== exp_pp1) begin errors++; $display("FAIL rel_pc1 cyc %0d got %h want %h", i, pc_plus1, exp_pp1); end
            if (i == 0) begin
                checks++;
                if (pc_plus1 !== held_pp1 + 16'd1) begin errors++; $display("FAIL skid_first got %h want %h", pc_plus1, held_pp1 + 16'd1); end
            end
        end
    endtask

    task automatic test_redirect_stall();
        repeat (3) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 16'h0040, 1'b0);
        checks += 2;
        if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL redir_rd_en got %b want 0", obs_rd_en); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b want 0", instr_valid); end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 3;
        if (obs_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr got %h want 0040", obs_addr); end
        if (obs_rd_en !== 1'b1) begin errors++; $display("FAIL redir_rd_en2 got %b want 1", obs_rd_en); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_inflight got %b want 0", instr_valid); end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 3;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got %b want 1", instr_valid); end
        if (instr !== mem_word(16'h0040)) begin errors++; $display("FAIL redir_instr got %h want %h", instr, mem_word(16'h0040)); end
        if (pc_plus1 !== 16'h0041) begin errors++; $display("FAIL redir_pc1 got %h want 0041", pc_plus1); end
    endtask

    task automatic test_halt();
        logic [15:0] held_addr;
        repeat (3) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b0, 1'b1, 16'h0123, 1'b1);
        held_addr = obs_addr;
        checks += 3;
        if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL halt_rd_en got %b want 0", obs_rd_en); end
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", instr_valid); end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'b1, 16'h0200, 1'b0);
            checks += 4;
            if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL halted_rd_en cyc %0d got %b want 0", i, obs_rd_en); end
            if (obs_addr !== held_addr) begin errors++; $display("FAIL halted_addr cyc %0d got %h want %h", i, obs_addr, held_addr); end
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL halted_valid cyc %0d got %b want 0", i, instr_valid); end
            if (halted !== 1'b1) begin errors++; $display("FAIL halted_flag cyc %0d got %b want 1", i, halted); end
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (obs2_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got %h want ffff", obs2_addr); end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        checks += 4;
        if (obs2_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got %h want 0000", obs2_addr); end
        if (instr_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", instr_valid2); end
        if (pc_plus1_2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc1 got %h want 0000", pc_plus1_2); end
        if (instr2 !== mem_word(16'hFFFF)) begin errors++; $display("FAIL wrap_instr got %h want %h", instr2, mem_word(16'hFFFF)); end
    endtask

    task automatic test_random();
        logic st, rd;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 15) == 0);
            drive_cycle(st, rd, 16'($urandom), 1'b0);
            checks += 6;
            if (obs_rd_en !== exp_rd_en) begin errors++; $display("FAIL rnd_rd_en cyc %0d got %b want %b", i, obs_rd_en, exp_rd_en); end
            if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, obs_addr, exp_addr); end
            if (instr !== exp_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, instr, exp_instr); end
            if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, instr_valid, exp_valid); end
            if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, halted, m_halted); end
            if ({opcode, x_bit, wait_time} !== {exp_instr[31:27], exp_instr[26], exp_instr[10:0]}) begin
                errors++; $display("FAIL rnd_fields cyc %0d got %b/%b/%h instr %h", i, opcode, x_bit, wait_time, exp_instr);
            end
            if (exp_valid) begin
                checks++;
                if (pc_plus1 !== exp_pp1) begin errors++; $display("FAIL rnd_pc1 cyc %0d got %h want %h", i, pc_plus1, exp_pp1); end
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset_dut();
        repeat (11) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        checks += 2;
        if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL perf_fetch got %0d want 10", fetch_cnt); end
        if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", stall_cnt); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
